// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths, special instruction encodings
// and the fetch-stage state encoding.
package cpu_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [31:0] HALT_WORD = 32'h0000_0000;
    localparam logic [31:0] NOP       = 32'h1000_0000;

    typedef logic [1:0] fetchState_t;

    localparam fetchState_t ST_RUN    = 2'd0;
    localparam fetchState_t ST_DRAIN  = 2'd1;
    localparam fetchState_t ST_HALTED = 2'd2;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port, executor redirect
// input and the instruction valid/ready handshake towards the executor.
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_inst;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              halted;

    modport master (
        output imem_en, imem_addr, inst_valid, inst_out, inst_pc, halted,
        input  imem_inst, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_en, imem_addr, inst_valid, inst_out, inst_pc, halted,
        output imem_inst, redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs. No bypass path:
// a pushed entry becomes visible at the head on the following cycle.
// Flush empties the queue and wins over a same-cycle push.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       pushData_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       headData_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             doPop;
    logic             doPush;
    logic             full;

    assign empty_o    = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign headData_o = mem_q[rdPtr_q];

    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && !flush_i && (!full || doPop);

    // Next pointer and occupancy values; flush simply returns to empty.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPop) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            if (doPush) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            count_d = count_q + CW'(doPush) - CW'(doPop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one-cycle-latency reads
// to instruction memory, buffers returned words and hands them to the
// executor. Redirects bump an epoch bit so stale in-flight reads are dropped.
module fetch_unit #(
    parameter int                ADDR_W    = cpu_pkg::ADDR_W,
    parameter int                DATA_W    = cpu_pkg::DATA_W,
    parameter int                DEPTH     = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(1),
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(cpu_pkg::HALT_WORD)
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    import cpu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    fetchState_t                state_q, state_d;
    logic [ADDR_W-1:0]          fetchPc_q, fetchPc_d;
    logic                       epoch_q, epoch_d;
    logic                       inflight_q;
    logic                       tagEpoch_q;
    logic [ADDR_W-1:0]          tagPc_q;

    logic [CW-1:0]              count;
    logic                       qEmpty;
    logic [ADDR_W+DATA_W-1:0]   headData;
    logic                       redirect;
    logic                       deq;
    logic                       respValid;
    logic                       respHalt;
    logic                       issue;
    logic [CW:0]                occupancy;

    assign redirect  = bus.redirect_valid && (state_q != ST_HALTED);
    assign respValid = inflight_q && (tagEpoch_q == epoch_q);
    assign respHalt  = respValid && (bus.imem_inst == HALT_WORD);

    assign bus.inst_valid = !rst && !qEmpty && (state_q != ST_HALTED);
    assign bus.inst_out   = headData[DATA_W-1:0];
    assign bus.inst_pc    = headData[ADDR_W+DATA_W-1:DATA_W];
    assign bus.halted     = !rst && (state_q == ST_HALTED);
    assign deq            = bus.inst_valid && bus.inst_ready;

    // Queued plus in-flight words, counting a head that leaves this cycle as gone.
    assign occupancy = (CW+1)'(count) + (CW+1)'(inflight_q) - (CW+1)'(deq);

    assign issue = !rst && (state_q == ST_RUN) && !bus.redirect_valid && !respHalt
                   && (occupancy < (CW+1)'(DEPTH));

    assign bus.imem_en   = issue;
    assign bus.imem_addr = fetchPc_q;

    // Next fetch PC, epoch and run/drain/halted state.
    always_comb begin
        fetchPc_d = fetchPc_q;
        epoch_d   = epoch_q;
        state_d   = state_q;
        if (redirect) begin
            fetchPc_d = bus.redirect_pc;
            epoch_d   = ~epoch_q;
            state_d   = ST_RUN;
        end else begin
            if (issue) begin
                fetchPc_d = fetchPc_q + PC_STEP;
            end
            case (state_q)
                ST_RUN: begin
                    if (respHalt) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (deq && (bus.inst_out == HALT_WORD)) begin
                        state_d = ST_HALTED;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Architectural fetch state plus the tag travelling with an outstanding read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            fetchPc_q  <= RESET_PC;
            epoch_q    <= 1'b0;
            inflight_q <= 1'b0;
            tagEpoch_q <= 1'b0;
            tagPc_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetchPc_q  <= fetchPc_d;
            epoch_q    <= epoch_d;
            inflight_q <= issue;
            if (issue) begin
                tagEpoch_q <= epoch_q;
                tagPc_q    <= fetchPc_q;
            end
        end
    end

    fetch_queue #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) uQueue (
        .clk        (clk),
        .rst        (rst),
        .push_i     (respValid),
        .pushData_i ({tagPc_q, bus.imem_inst}),
        .pop_i      (deq),
        .flush_i    (redirect),
        .headData_o (headData),
        .count_o    (count),
        .empty_o    (qEmpty)
    );

endmodule
